instr_fetch_ctrl: RTL

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_pkg.sv | 13 +
 rtl/fetch_skid_buf.sv | 75 +++++++
 rtl/instr_fetch_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer holding fetched words and their byte addresses.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic [31:0] push_pc,
  input  logic        pop,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] head_data,
  output logic [31:0] head_pc,
  output logic [1:0]  count
);

  logic [31:0] data_q [2];
  logic [31:0] pc_q   [2];
  logic [31:0] data_d [2];
  logic [31:0] pc_d   [2];
  logic [1:0]  count_q, count_d;
  logic        pop_eff;
  logic [1:0]  count_after_pop;

  assign pop_eff         = pop && (count_q != 2'd0);
  assign count_after_pop = count_q - {1'b0, pop_eff};
  assign valid           = (count_q != 2'd0);
  assign head_data       = data_q[0];
  assign head_pc         = pc_q[0];
  assign count           = count_q;

  // Next contents: retire the head first, then append at the first free slot.
  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    count_d = count_after_pop;
    if (pop_eff) begin
      data_d[0] = data_q[1];
      pc_d[0]   = pc_q[1];
    end
    if (push && (count_after_pop != 2'd2)) begin
      if (count_after_pop == 2'd0) begin
        data_d[0] = push_data;
        pc_d[0]   = push_pc;
      end else begin
        data_d[1] = push_data;
        pc_d[1]   = push_pc;
      end
      count_d = count_after_pop + 2'd1;
    end
    if (flush) begin
      count_d = 2'd0;
    end
  end

  // Buffer registers; reset clears entries so inst/inst_pc read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
      count_q   <= 2'd0;
    end else begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // The issue rule upstream must never let a write land on a full buffer.
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && (count_after_pop == 2'd2)));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: pc sequencing, one-deep in-flight tracking
// against a 1-cycle-latency memory, and a 2-entry buffer toward the decoder.
//
// state | meaning
// IDLE  | after reset, waiting for start; no fetches
// RUN   | issuing fetches while buffer + in-flight has room
// HALT  | no new fetches; outstanding work drains to the decoder
module instr_fetch_ctrl
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  tag_q;
  logic         inflight_q;
  logic         pop;
  logic         issue;
  logic         push;
  logic [1:0]   buf_count;
  logic [2:0]   occupancy;

  assign pop       = inst_valid & inst_ready;
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  // A redirect cycle never issues: the old pc is stale and the target is
  // only loaded at the edge.
  assign issue     = (state_q == RUN) && !redirect_valid && (occupancy < 3'd2);
  assign push      = inflight_q && !redirect_valid;
  assign mem_addr  = {2'b00, pc_q[31:2]};

  // Next-state logic; halt wins over start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !halt) state_d = RUN;
      RUN:     if (halt)           state_d = HALT;
      HALT:    if (start && !halt) state_d = RUN;
      default:                     state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // pc and in-flight tracking; a redirect kills the outstanding fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc & ~32'h0000_0003;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_q <= pc_q;
        pc_q  <= pc_q + INSTR_BYTES;
      end
    end
  end

  fetch_skid_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_rdata),
    .push_pc   (tag_q),
    .pop       (pop),
    .flush     (redirect_valid),
    .valid     (inst_valid),
    .head_data (inst),
    .head_pc   (inst_pc),
    .count     (buf_count)
  );

endmodule
